// File: rtl/reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : reset_sequencer
// Description : Holds the downstream subsystem resets after the board reset
//               and releases them one at a time, in index order. Each release
//               follows a fixed gap. The next gap starts only after the stage
//               just released acknowledges. A one-cycle soft_req restarts the
//               whole sequence.
//               Optional macro RESET_SEQ_TIMEOUT_EN adds a per-stage
//               acknowledgment timeout. On a timeout the design parks in a
//               fault state that reports the failing stage index.
// Revision    : 1.0 - initial release
// ============================================================================
module reset_sequencer #(
    parameter int STAGES         = 4,
    parameter int GAP_CYCLES     = 1000,
    parameter int TIMEOUT_CYCLES = 100000,
    localparam int c_idx_w       = (STAGES > 1) ? $clog2(STAGES) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               soft_req,
    input  logic [STAGES-1:0]  stage_ack,
    output logic [STAGES-1:0]  stage_rst,
    output logic               all_ready,
    output logic               busy,
    output logic               timeout_err,
    output logic [c_idx_w-1:0] fail_stage
);

    // The counter serves both the release gap and the acknowledgment timeout.
    localparam int c_cnt_max = (GAP_CYCLES > TIMEOUT_CYCLES) ? GAP_CYCLES : TIMEOUT_CYCLES;
    localparam int c_cnt_w   = $clog2(c_cnt_max + 1);

    localparam logic [c_cnt_w-1:0] c_gap_last = c_cnt_w'(GAP_CYCLES - 1);
    localparam logic [c_idx_w-1:0] c_idx_last = c_idx_w'(STAGES - 1);
`ifdef RESET_SEQ_TIMEOUT_EN
    localparam logic [c_cnt_w-1:0] c_to_last  = c_cnt_w'(TIMEOUT_CYCLES - 1);
`endif

    typedef enum logic [1:0] {
        S_GAP      = 2'd0,
        S_WAIT_ACK = 2'd1,
        S_DONE     = 2'd2,
        S_FAULT    = 2'd3
    } state_t;

    state_t               r_state;
    logic [c_idx_w-1:0]   r_idx;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [STAGES-1:0]    r_stage_rst;
    logic                 r_all_ready;
    logic                 r_busy;
    logic                 r_timeout_err;
    logic [c_idx_w-1:0]   r_fail_stage;

    state_t               w_state_nx;
    logic [c_idx_w-1:0]   w_idx_nx;
    logic [c_cnt_w-1:0]   w_cnt_nx;
    logic [STAGES-1:0]    w_stage_rst_nx;
    logic                 w_all_ready_nx;
    logic                 w_busy_nx;
    logic                 w_timeout_err_nx;
    logic [c_idx_w-1:0]   w_fail_stage_nx;

    // State, counters and all outputs register here; reset returns everything
    // to the fully-held, sequencing-from-scratch condition.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_GAP;
            r_idx         <= '0;
            r_cnt         <= '0;
            r_stage_rst   <= '1;
            r_all_ready   <= 1'b0;
            r_busy        <= 1'b1;
            r_timeout_err <= 1'b0;
            r_fail_stage  <= '0;
        end else begin
            r_state       <= w_state_nx;
            r_idx         <= w_idx_nx;
            r_cnt         <= w_cnt_nx;
            r_stage_rst   <= w_stage_rst_nx;
            r_all_ready   <= w_all_ready_nx;
            r_busy        <= w_busy_nx;
            r_timeout_err <= w_timeout_err_nx;
            r_fail_stage  <= w_fail_stage_nx;
        end
    end

    // Next-state and next-output logic; soft_req overrides any transition.
    always_comb begin
        w_state_nx       = r_state;
        w_idx_nx         = r_idx;
        w_cnt_nx         = r_cnt;
        w_stage_rst_nx   = r_stage_rst;
        w_all_ready_nx   = r_all_ready;
        w_busy_nx        = r_busy;
        w_timeout_err_nx = r_timeout_err;
        w_fail_stage_nx  = r_fail_stage;

        if (soft_req) begin
            w_state_nx       = S_GAP;
            w_idx_nx         = '0;
            w_cnt_nx         = '0;
            w_stage_rst_nx   = '1;
            w_all_ready_nx   = 1'b0;
            w_busy_nx        = 1'b1;
            w_timeout_err_nx = 1'b0;
        end else begin
            case (r_state)
                S_GAP: begin
                    if (r_cnt == c_gap_last) begin
                        w_stage_rst_nx[r_idx] = 1'b0;
                        w_cnt_nx              = '0;
                        w_state_nx            = S_WAIT_ACK;
                    end else begin
                        w_cnt_nx = r_cnt + c_cnt_w'(1);
                    end
                end
                S_WAIT_ACK: begin
                    // Only the stage just released is looked at.
                    if (stage_ack[r_idx]) begin
                        if (r_idx == c_idx_last) begin
                            w_state_nx     = S_DONE;
                            w_all_ready_nx = 1'b1;
                            w_busy_nx      = 1'b0;
                        end else begin
                            w_idx_nx   = r_idx + c_idx_w'(1);
                            w_cnt_nx   = '0;
                            w_state_nx = S_GAP;
                        end
                    end
`ifdef RESET_SEQ_TIMEOUT_EN
                    else if (r_cnt == c_to_last) begin
                        // Put the silent stage back into reset; earlier stages stay up.
                        w_state_nx            = S_FAULT;
                        w_stage_rst_nx[r_idx] = 1'b1;
                        w_timeout_err_nx      = 1'b1;
                        w_fail_stage_nx       = r_idx;
                        w_busy_nx             = 1'b0;
                        w_all_ready_nx        = 1'b0;
                    end
`endif
                    else begin
                        w_cnt_nx = r_cnt + c_cnt_w'(1);
                    end
                end
                S_DONE:  ;
                S_FAULT: ;
                default: w_state_nx = S_GAP;
            endcase
        end
    end

    assign stage_rst   = r_stage_rst;
    assign all_ready   = r_all_ready;
    assign busy        = r_busy;
    assign timeout_err = r_timeout_err;
    assign fail_stage  = r_fail_stage;

endmodule
`default_nettype wire

// File: tb/tb_reset_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_reset_sequencer
// Description : Directed self-checking bench for reset_sequencer with
//               STAGES=3, GAP_CYCLES=4 and TIMEOUT_CYCLES=10. Edge numbers
//               count the edges after the last reset (or soft_req) edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reset_sequencer;

    localparam int STAGES  = 3;
    localparam int GAP     = 4;
    localparam int TIMEOUT = 10;

    logic              clk = 1'b0;
    logic              reset;
    logic              soft_req;
    logic [STAGES-1:0] stage_ack;
    logic [STAGES-1:0] stage_rst;
    logic              all_ready;
    logic              busy;
    logic              timeout_err;
    logic [1:0]        fail_stage;

    int n_checks = 0;
    int n_err    = 0;
    int edge_n   = 0;

    reset_sequencer #(
        .STAGES         (STAGES),
        .GAP_CYCLES     (GAP),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) u_dut (
        .clk         (clk),
        .reset       (reset),
        .soft_req    (soft_req),
        .stage_ack   (stage_ack),
        .stage_rst   (stage_rst),
        .all_ready   (all_ready),
        .busy        (busy),
        .timeout_err (timeout_err),
        .fail_stage  (fail_stage)
    );

    // 10 MHz clock
    always #50 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        edge_n++;
    endtask

    task automatic run_to(input int n);
        while (edge_n < n) tick();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s @edge %0d: observed=%0h expected=%0h", tag, edge_n, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        soft_req = 1'b0;
        tick();
        tick();
        reset  = 1'b0;
        edge_n = 0;
    endtask

    // Directed scenarios in sequence
    initial begin
        reset     = 1'b1;
        soft_req  = 1'b0;
        stage_ack = 3'b111;
        repeat (3) tick();

        // Reset values
        chk("rst_stage_rst", stage_rst, 3'b111);
        chk("rst_all_ready", all_ready, 0);
        chk("rst_busy", busy, 1);
        chk("rst_timeout_err", timeout_err, 0);
        chk("rst_fail_stage", fail_stage, 0);

        // Nominal sequence, acknowledgments already high
        reset  = 1'b0;
        edge_n = 0;
        run_to(3);  chk("nom_e3", stage_rst, 3'b111);
        run_to(4);  chk("nom_e4", stage_rst, 3'b110);
        run_to(8);  chk("nom_e8", stage_rst, 3'b110);
        run_to(9);  chk("nom_e9", stage_rst, 3'b100);
        run_to(13); chk("nom_e13", stage_rst, 3'b100);
        chk("nom_e13_busy", busy, 1);
        run_to(14); chk("nom_e14", stage_rst, 3'b000);
        chk("nom_e14_ready", all_ready, 0);
        run_to(15); chk("nom_e15_ready", all_ready, 1);
        chk("nom_e15_busy", busy, 0);

        // DONE ignores acknowledgment changes
        stage_ack = 3'b000;
        run_to(20);
        chk("done_hold_rst", stage_rst, 3'b000);
        chk("done_hold_ready", all_ready, 1);
        stage_ack = 3'b111;

        // Soft restart from DONE
        run_to(29);
        soft_req = 1'b1;
        run_to(30);
        soft_req = 1'b0;
        chk("soft_e30_rst", stage_rst, 3'b111);
        chk("soft_e30_ready", all_ready, 0);
        chk("soft_e30_busy", busy, 1);
        run_to(33); chk("soft_e33", stage_rst, 3'b111);
        run_to(34); chk("soft_e34", stage_rst, 3'b110);
        run_to(44); chk("soft_e44_rst", stage_rst, 3'b000);
        chk("soft_e44_ready", all_ready, 0);
        run_to(45); chk("soft_e45_ready", all_ready, 1);

        // Slow acknowledgment on stage 1: first sampled high at edge 16
        do_reset();
        stage_ack = 3'b101;
        run_to(9);  chk("slow_e9", stage_rst, 3'b100);
        run_to(15); chk("slow_e15", stage_rst, 3'b100);
        chk("slow_e15_busy", busy, 1);
        stage_ack = 3'b111;
        run_to(19); chk("slow_e19", stage_rst, 3'b100);
        run_to(20); chk("slow_e20", stage_rst, 3'b000);
        chk("slow_e20_ready", all_ready, 0);
        run_to(21); chk("slow_e21_ready", all_ready, 1);
        chk("slow_e21_busy", busy, 0);

        // soft_req beats the release that would occur at the same edge
        do_reset();
        run_to(3);
        soft_req = 1'b1;
        run_to(4);
        soft_req = 1'b0;
        chk("softwin_e4", stage_rst, 3'b111);
        edge_n = 0;
        run_to(3); chk("softwin_re3", stage_rst, 3'b111);
        run_to(4); chk("softwin_re4", stage_rst, 3'b110);

        // Mid-sequence reset together with soft_req
        do_reset();
        run_to(10); chk("mid_e10", stage_rst, 3'b100);
        reset    = 1'b1;
        soft_req = 1'b1;
        run_to(11);
        chk("mid_e11_rst", stage_rst, 3'b111);
        chk("mid_e11_busy", busy, 1);
        chk("mid_e11_ready", all_ready, 0);
        reset    = 1'b0;
        soft_req = 1'b0;
        edge_n   = 0;
        run_to(3);  chk("mid_re3", stage_rst, 3'b111);
        run_to(4);  chk("mid_re4", stage_rst, 3'b110);
        run_to(9);  chk("mid_re9", stage_rst, 3'b100);
        run_to(14); chk("mid_re14", stage_rst, 3'b000);
        run_to(15); chk("mid_re15_ready", all_ready, 1);

`ifdef RESET_SEQ_TIMEOUT_EN
        // Stage 1 never acknowledges -> fault at edge 19
        do_reset();
        stage_ack = 3'b101;
        run_to(9);  chk("to_e9", stage_rst, 3'b100);
        run_to(18); chk("to_e18", stage_rst, 3'b100);
        chk("to_e18_err", timeout_err, 0);
        chk("to_e18_busy", busy, 1);
        run_to(19);
        chk("to_e19_rst", stage_rst, 3'b110);
        chk("to_e19_err", timeout_err, 1);
        chk("to_e19_fail", fail_stage, 1);
        chk("to_e19_busy", busy, 0);
        chk("to_e19_ready", all_ready, 0);
        stage_ack = 3'b111;
        run_to(25);
        chk("to_e25_rst", stage_rst, 3'b110);
        chk("to_e25_err", timeout_err, 1);
        soft_req = 1'b1;
        tick();
        soft_req = 1'b0;
        chk("to_soft_err", timeout_err, 0);
        chk("to_soft_rst", stage_rst, 3'b111);
        chk("to_soft_busy", busy, 1);
        do_reset();
        chk("to_reset_fail", fail_stage, 0);
`else
        // Stage 0 silent for 1000 cycles: waits forever, no fault
        do_reset();
        stage_ack = 3'b110;
        run_to(4); chk("wait_e4", stage_rst, 3'b110);
        for (int i = 0; i < 1000; i++) begin
            tick();
            chk("wait_rst", stage_rst, 3'b110);
            chk("wait_busy", busy, 1);
            chk("wait_err", timeout_err, 0);
            chk("wait_fail", fail_stage, 0);
        end
        stage_ack = 3'b111;
        run_to(1008); chk("wait_e1008", stage_rst, 3'b110);
        run_to(1009); chk("wait_e1009", stage_rst, 3'b100);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
`default_nettype wire
